seq_detect_param: RTL and testbench

//  Parametrised serial-pattern detector for the board I/O path. Each debounced

---
 rtl/seq_detect_pkg.sv | 10 +
 rtl/btn_edge_sync.sv | 22 ++
 rtl/seq_detect_param.sv | 131 +++++++++++++
 tb/tb_seq_detect_param.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants for the serial-pattern detector: display slot map and digit width.
package seq_detect_pkg;
  localparam int NUM_SLOTS = 5;
  localparam int DIGIT_W   = 4;
  localparam logic [2:0] SLOT_CNT_LO  = 3'd0;
  localparam logic [2:0] SLOT_CNT_HI  = 3'd1;
  localparam logic [2:0] SLOT_PROG    = 3'd2;
  localparam logic [2:0] SLOT_HIST_LO = 3'd3;
  localparam logic [2:0] SLOT_HIST_HI = 3'd4;
endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop button synchroniser with rising-edge detect; one step per press.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic step
);
  logic b1;
  logic b2;

  always_ff @(posedge clk) begin
    if (rst) begin
      b1 <= 1'b0;
      b2 <= 1'b0;
    end else begin
      b1 <= button;
      b2 <= b1;
    end
  end

  assign step = b1 & ~b2;
endmodule

// File: rtl/seq_detect_param.sv
// Serial-pattern detector: button-stepped sampling of din, match counting and a
// time-multiplexed hex display of count, match progress and history.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1100,
  parameter int               CNT_W    = 8,
  parameter int               SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               button,
  input  logic               mode_overlap,
  input  logic               clear,
  output logic               hit,
  output logic [CNT_W-1:0]   count,
  output logic [PAT_W-1:0]   history,
  output logic [2:0]         AN,
  output logic [DIGIT_W-1:0] D
);
  localparam int VAL_W = 4;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic             step;
  logic [VAL_W-1:0] valid;
  logic             last_match;
  logic [PAT_W-1:0] hist_nx;
  logic [VAL_W-1:0] valid_nx;
  logic             m;
  logic [3:0]       progress;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       slot;
  logic [7:0]       cnt8;
  logic [7:0]       hist8;
  logic [DIGIT_W-1:0] digit;

  btn_edge_sync u_edge (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .step   (step)
  );

  assign hist_nx  = {history[PAT_W-2:0], din};
  assign valid_nx = (valid == VAL_W'(PAT_W)) ? valid : valid + 1'b1;
  assign m        = (hist_nx == PATTERN) && (valid_nx == VAL_W'(PAT_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      history    <= '0;
      valid      <= '0;
      count      <= '0;
      hit        <= 1'b0;
      last_match <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (clear) begin
        history    <= '0;
        valid      <= '0;
        count      <= '0;
        last_match <= 1'b0;
      end else if (step) begin
        history    <= hist_nx;
        last_match <= m;
        hit        <= m;
        // Non-overlapping mode forgets the consumed bits by restarting the fill.
        valid      <= (m && !mode_overlap) ? '0 : valid_nx;
        if (m && (count != {CNT_W{1'b1}}))
          count <= count + 1'b1;
      end
    end
  end

  // Longest pattern prefix present at the newest end of the history.
  always_comb begin
    logic             ok;
    logic [PAT_W-1:0] pat_sh;
    progress = 4'd0;
    ok       = 1'b0;
    pat_sh   = '0;
    for (int k = 1; k < PAT_W; k++) begin
      if (k <= int'(valid)) begin
        pat_sh = PATTERN >> (PAT_W - k);
        ok     = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
          if (i < k && history[i] != pat_sh[i])
            ok = 1'b0;
        end
        if (ok)
          progress = 4'(k);
      end
    end
    if (last_match)
      progress = 4'(PAT_W);
  end

  assign cnt8  = 8'(count);
  assign hist8 = 8'(history);

  always_comb begin
    digit = '0;
    case (slot)
      SLOT_CNT_LO:  digit = cnt8[3:0];
      SLOT_CNT_HI:  digit = cnt8[7:4];
      SLOT_PROG:    digit = progress;
      SLOT_HIST_LO: digit = hist8[3:0];
      SLOT_HIST_HI: digit = hist8[7:4];
      default:      digit = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= '0;
      AN      <= '0;
      D       <= '0;
    end else begin
      AN <= slot;
      D  <= digit;
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        slot    <= (slot == 3'(NUM_SLOTS - 1)) ? 3'd0 : slot + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four parameterisations share one stimulus bus.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst, din, button, mode_overlap, clear;

  wire       hit_s  [4];
  wire [3:0] hist_s [4];
  wire [2:0] an_s   [4];
  wire [3:0] d_s    [4];
  wire [7:0] count_a, count_b, count_d;
  wire [3:0] count_c;

  int checks   = 0;
  int failures = 0;
  int hits [4];
  int tot_c;
  logic [3:0] v;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1100), .CNT_W(8), .SCAN_DIV(2)) u_a (
    .clk(clk), .rst(rst), .din(din), .button(button), .mode_overlap(mode_overlap),
    .clear(clear), .hit(hit_s[0]), .count(count_a), .history(hist_s[0]),
    .AN(an_s[0]), .D(d_s[0]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8), .SCAN_DIV(2)) u_b (
    .clk(clk), .rst(rst), .din(din), .button(button), .mode_overlap(mode_overlap),
    .clear(clear), .hit(hit_s[1]), .count(count_b), .history(hist_s[1]),
    .AN(an_s[1]), .D(d_s[1]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1100), .CNT_W(4), .SCAN_DIV(2)) u_c (
    .clk(clk), .rst(rst), .din(din), .button(button), .mode_overlap(mode_overlap),
    .clear(clear), .hit(hit_s[2]), .count(count_c), .history(hist_s[2]),
    .AN(an_s[2]), .D(d_s[2]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b0110), .CNT_W(8), .SCAN_DIV(2)) u_d (
    .clk(clk), .rst(rst), .din(din), .button(button), .mode_overlap(mode_overlap),
    .clear(clear), .hit(hit_s[3]), .count(count_d), .history(hist_s[3]),
    .AN(an_s[3]), .D(d_s[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; button = 1'b0; clear = 1'b0; din = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // One press; hits[] counts the cycles each instance shows hit during the press.
  task automatic press(input logic d, input logic clr);
    for (int n = 0; n < 4; n++) hits[n] = 0;
    @(negedge clk);
    din = d; clear = clr; button = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) hits[n] += int'(hit_s[n]);
      if (i == 1) begin
        button = 1'b0;
        clear  = 1'b0;
      end
    end
  endtask

  task automatic get_digit(input int inst, input logic [2:0] slot, output logic [3:0] val);
    logic found;
    found = 1'b0;
    val   = '0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (an_s[inst] == slot) begin
        val   = d_s[inst];
        found = 1'b1;
      end
    end
    if (!found) check("slot_timeout", 32'(slot), 32'hFFFF);
  endtask

  initial begin
    logic [2:0] prev;
    logic       aligned;
    logic [3:0] exp_d [5];
    exp_d[0] = 4'hA; exp_d[1] = 4'h3; exp_d[2] = 4'h4; exp_d[3] = 4'h6; exp_d[4] = 4'h0;
    rst = 1'b1; din = 1'b0; button = 1'b0; mode_overlap = 1'b1; clear = 1'b0;

    // Reset state
    do_reset();
    check("rst_hit", 32'(hit_s[0]), 0);
    check("rst_count", 32'(count_a), 0);
    check("rst_history", 32'(hist_s[0]), 0);
    check("rst_an", 32'(an_s[0]), 0);
    check("rst_d", 32'(d_s[0]), 0);

    // 1: pattern 1100, overlapping
    mode_overlap = 1'b1;
    press(1, 0); press(1, 0); press(0, 0);
    check("t1_no_early_hit", 32'(hits[0]), 0);
    press(0, 0);
    check("t1_hit_pulse", 32'(hits[0]), 1);
    check("t1_count", 32'(count_a), 1);
    check("t1_history", 32'(hist_s[0]), 4'b1100);
    get_digit(0, 3'd2, v); check("t1_progress", 32'(v), 4);
    get_digit(0, 3'd0, v); check("t1_cnt_digit", 32'(v), 1);
    get_digit(0, 3'd3, v); check("t1_hist_digit", 32'(v), 4'hC);
    press(0, 0);
    get_digit(0, 3'd2, v); check("t1_progress_0", 32'(v), 0);
    press(1, 0);
    get_digit(0, 3'd2, v); check("t1_progress_1", 32'(v), 1);

    // 2: pattern 1010, overlap then non-overlap
    do_reset();
    mode_overlap = 1'b1;
    press(1, 0); press(0, 0); press(1, 0); press(0, 0);
    check("t2o_hit4", 32'(hits[1]), 1);
    press(1, 0); press(0, 0);
    check("t2o_hit6", 32'(hits[1]), 1);
    check("t2o_count", 32'(count_b), 2);
    do_reset();
    mode_overlap = 1'b0;
    press(1, 0); press(0, 0); press(1, 0); press(0, 0);
    check("t2n_hit4", 32'(hits[1]), 1);
    press(1, 0); press(0, 0);
    check("t2n_hit6", 32'(hits[1]), 0);
    check("t2n_count", 32'(count_b), 1);
    check("t2n_history", 32'(hist_s[1]), 4'b1010);
    get_digit(1, 3'd2, v); check("t2n_progress", 32'(v), 2);

    // 3: saturation on a 4-bit counter
    do_reset();
    mode_overlap = 1'b1;
    tot_c = 0;
    for (int r = 0; r < 20; r++) begin
      press(1, 0); press(1, 0); press(0, 0); press(0, 0);
      tot_c += hits[2];
    end
    check("t3_hits", 32'(tot_c), 20);
    check("t3_count_sat", 32'(count_c), 15);
    check("t3_count_wide", 32'(count_a), 20);
    get_digit(2, 3'd1, v); check("t3_cnt_hi_digit", 32'(v), 0);

    // 4: clear coincident with a step
    do_reset();
    mode_overlap = 1'b1;
    press(1, 0); press(1, 0); press(0, 0); press(0, 0);
    check("t4_pre_count", 32'(count_a), 1);
    press(1, 0); press(1, 0); press(0, 0);
    press(0, 1);
    check("t4_clr_hit", 32'(hits[0]), 0);
    check("t4_clr_history", 32'(hist_s[0]), 0);
    check("t4_clr_count", 32'(count_a), 0);
    press(1, 0); press(1, 0); press(0, 0);
    check("t4_post_no_hit", 32'(hits[0]), 0);
    check("t4_post_history", 32'(hist_s[0]), 4'b0110);
    press(0, 0);
    check("t4_post_hit", 32'(hits[0]), 1);
    check("t4_post_count", 32'(count_a), 1);

    // 5: held button and button held through reset release
    do_reset();
    @(negedge clk);
    din = 1'b1; button = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_held_one", 32'(hist_s[0]), 4'b0001);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_mid_rst", 32'(hist_s[0]), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_after_rst", 32'(hist_s[0]), 4'b0001);
    button = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_release", 32'(hist_s[0]), 4'b0001);

    // 6: count 0x3A with history 0110, then watch the scan
    do_reset();
    mode_overlap = 1'b1;
    press(0, 0); press(1, 0); press(1, 0); press(0, 0);
    for (int r = 0; r < 57; r++) begin
      press(1, 0); press(1, 0); press(0, 0);
    end
    check("t6_count", 32'(count_d), 8'h3A);
    check("t6_history", 32'(hist_s[3]), 4'b0110);
    aligned = 1'b0;
    prev = an_s[3];
    for (int i = 0; i < 30 && !aligned; i++) begin
      @(negedge clk);
      if (an_s[3] == 3'd0 && prev == 3'd4) aligned = 1'b1;
      else prev = an_s[3];
    end
    check("t6_aligned", 32'(aligned), 1);
    if (aligned) begin
      for (int j = 0; j < 11; j++) begin
        if (j > 0) @(negedge clk);
        check($sformatf("t6_an_%0d", j), 32'(an_s[3]), 32'((j / 2) % 5));
        check($sformatf("t6_d_%0d", j), 32'(d_s[3]), 32'(exp_d[(j / 2) % 5]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
